alu_decode_stage: RTL and testbench

Registered decode/issue stage that sits in front of the combinational ALU. Accepts one 32-bit MIPS-style instruction per cycle with its register-file read values. Produces the ALU command, both ALU operands, the destination register index and a write enable. The result is held in a valid/ready pipeline register, so decode and execute are decoupled by exactly one stage.

---
 rtl/alu_decode_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// Registered decode/issue stage ahead of the ALU: MIPS-style instruction -> ALU command/operands.
// Optional sticky illegal-instruction trap is enabled by defining ALU_DECODE_TRAP_EN.
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  cmd,
    output logic [31:0] opa,
    output logic [31:0] opb,
    output logic [4:0]  dst,
    output logic        wr_en,
    output logic        illegal
);

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_LU   = 4'd7;
    localparam logic [3:0] ALU_SLLV = 4'd8;
    localparam logic [3:0] ALU_SRLV = 4'd9;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;

    assign opcode = instr[31:26];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign imm_sx = {{16{imm[15]}}, imm};
    assign imm_zx = {16'b0, imm};

    // rs is read by the register file upstream; only its value reaches this stage.
    logic unused_rs_idx;
    assign unused_rs_idx = ^instr[25:21];

    logic [3:0]  d_cmd;
    logic [31:0] d_opa;
    logic [31:0] d_opb;
    logic [4:0]  d_dst;
    logic        d_legal;

    always_comb begin
        d_cmd   = ALU_AND;
        d_opa   = 32'b0;
        d_opb   = 32'b0;
        d_dst   = 5'b0;
        d_legal = 1'b0;
        if (opcode == 6'h00) begin
            d_legal = 1'b1;
            d_dst   = rd_idx;
            d_opa   = rs_val;
            d_opb   = rt_val;
            case (funct)
                6'h24:        d_cmd = ALU_AND;
                6'h25:        d_cmd = ALU_OR;
                6'h26:        d_cmd = ALU_XOR;
                6'h27:        d_cmd = ALU_NOR;
                6'h20, 6'h21: d_cmd = ALU_ADD;
                6'h22, 6'h23: d_cmd = ALU_SUB;
                6'h2A:        d_cmd = ALU_SLT;
                6'h04: begin
                    d_cmd = ALU_SLLV;
                    d_opa = rt_val;
                    d_opb = {27'b0, rs_val[4:0]};
                end
                6'h06: begin
                    d_cmd = ALU_SRLV;
                    d_opa = rt_val;
                    d_opb = {27'b0, rs_val[4:0]};
                end
                6'h00: begin
                    d_cmd = ALU_SLLV;
                    d_opa = rt_val;
                    d_opb = {27'b0, shamt};
                end
                6'h02: begin
                    d_cmd = ALU_SRLV;
                    d_opa = rt_val;
                    d_opb = {27'b0, shamt};
                end
                default: begin
                    d_legal = 1'b0;
                    d_dst   = 5'b0;
                    d_opa   = 32'b0;
                    d_opb   = 32'b0;
                end
            endcase
        end else begin
            d_legal = 1'b1;
            d_dst   = rt_idx;
            d_opa   = rs_val;
            case (opcode)
                6'h08, 6'h09: begin
                    d_cmd = ALU_ADD;
                    d_opb = imm_sx;
                end
                6'h0A: begin
                    d_cmd = ALU_SLT;
                    d_opb = imm_sx;
                end
                6'h0C: begin
                    d_cmd = ALU_AND;
                    d_opb = imm_zx;
                end
                6'h0D: begin
                    d_cmd = ALU_OR;
                    d_opb = imm_zx;
                end
                6'h0E: begin
                    d_cmd = ALU_XOR;
                    d_opb = imm_zx;
                end
                6'h0F: begin
                    d_cmd = ALU_LU;
                    d_opa = 32'b0;
                    d_opb = imm_zx;
                end
                default: begin
                    d_legal = 1'b0;
                    d_dst   = 5'b0;
                    d_opa   = 32'b0;
                end
            endcase
        end
    end

    logic accept;
    assign accept = in_valid && in_ready && !flush;

`ifdef ALU_DECODE_TRAP_EN
    logic trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap <= 1'b0;
        end else if (flush) begin
            trap <= 1'b0;
        end else if (accept && !d_legal) begin
            trap <= 1'b1;
        end
    end

    assign in_ready = (!out_valid || out_ready) && !trap;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only moves on accept so a stalled or flushed entry never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= 4'b0;
            opa     <= 32'b0;
            opb     <= 32'b0;
            dst     <= 5'b0;
            wr_en   <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            cmd     <= d_cmd;
            opa     <= d_opa;
            opb     <= d_opb;
            dst     <= d_dst;
            wr_en   <= d_legal && (d_dst != 5'b0);
            illegal <= !d_legal;
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: vector table plus handshake, flush, reset and illegal sequences.
`timescale 1ns/1ps
module tb_alu_decode_stage;

    localparam logic [3:0] C_AND  = 4'd0;
    localparam logic [3:0] C_OR   = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_SUB  = 4'd3;
    localparam logic [3:0] C_SLT  = 4'd4;
    localparam logic [3:0] C_NOR  = 4'd5;
    localparam logic [3:0] C_XOR  = 4'd6;
    localparam logic [3:0] C_LU   = 4'd7;
    localparam logic [3:0] C_SLLV = 4'd8;
    localparam logic [3:0] C_SRLV = 4'd9;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  cmd;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  dst;
    logic        wr_en;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    alu_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .cmd(cmd), .opa(opa), .opb(opb), .dst(dst),
        .wr_en(wr_en), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  cmd;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [4:0]  dst;
        logic        wr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] e_cmd, input logic [31:0] e_opa,
                           input logic [31:0] e_opb, input logic [4:0] e_dst,
                           input logic e_wr, input logic e_ill);
        chk({name, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, ".cmd"}, {28'b0, cmd}, {28'b0, e_cmd});
        chk({name, ".opa"}, opa, e_opa);
        chk({name, ".opb"}, opb, e_opb);
        chk({name, ".dst"}, {27'b0, dst}, {27'b0, e_dst});
        chk({name, ".wr_en"}, {31'b0, wr_en}, {31'b0, e_wr});
        chk({name, ".illegal"}, {31'b0, illegal}, {31'b0, e_ill});
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({name, ".cmd"}, {28'b0, cmd}, 32'd0);
        chk({name, ".opa"}, opa, 32'd0);
        chk({name, ".opb"}, opb, 32'd0);
        chk({name, ".dst"}, {27'b0, dst}, 32'd0);
        chk({name, ".wr_en"}, {31'b0, wr_en}, 32'd0);
        chk({name, ".illegal"}, {31'b0, illegal}, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        in_valid = v;
        instr    = i;
        rs_val   = rs;
        rt_val   = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h00221820, 32'd5,        32'd7,        C_ADD,  32'd5,        32'd7,        5'd3,  1'b1};
        vecs[1]  = '{32'h2024FFFF, 32'd5,        32'd0,        C_ADD,  32'd5,        32'hFFFFFFFF, 5'd4,  1'b1};
        vecs[2]  = '{32'h3C051234, 32'd9,        32'd0,        C_LU,   32'd0,        32'h00001234, 5'd5,  1'b1};
        vecs[3]  = '{32'h00011100, 32'h33,       32'd1,        C_SLLV, 32'd1,        32'd4,        5'd2,  1'b1};
        vecs[4]  = '{32'h34068000, 32'd0,        32'd0,        C_OR,   32'd0,        32'h00008000, 5'd6,  1'b1};
        vecs[5]  = '{32'h01093822, 32'd10,       32'd3,        C_SUB,  32'd10,       32'd3,        5'd7,  1'b1};
        vecs[6]  = '{32'h00620806, 32'hFFFFFF25, 32'h80000000, C_SRLV, 32'h80000000, 32'd5,        5'd1,  1'b1};
        vecs[7]  = '{32'h282AFFFE, 32'd3,        32'd0,        C_SLT,  32'd3,        32'hFFFFFFFE, 5'd10, 1'b1};
        vecs[8]  = '{32'h38228001, 32'h0000FFFF, 32'd0,        C_XOR,  32'h0000FFFF, 32'h00008001, 5'd2,  1'b1};
        vecs[9]  = '{32'h00220020, 32'd1,        32'd2,        C_ADD,  32'd1,        32'd2,        5'd0,  1'b0};
        vecs[10] = '{32'h00A62027, 32'hF0,       32'h0F,       C_NOR,  32'hF0,       32'h0F,       5'd4,  1'b1};
        vecs[11] = '{32'h3041FFFF, 32'h12345678, 32'd0,        C_AND,  32'h12345678, 32'h0000FFFF, 5'd1,  1'b1};

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        step();

        // Back-to-back stream, no bubbles.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
            chk($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].opa, vecs[i].opb,
                    vecs[i].dst, vecs[i].wr, 1'b0);
        end

        // Async reset with an op held.
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("midreset.in_ready", {31'b0, in_ready}, 32'd1);
        step();

        // Backpressure: A held for 3 cycles while B waits.
        out_ready = 1'b0;
        drive(1'b1, 32'h00221820, 32'd5, 32'd7);
        step();
        chk_out("bp.a", C_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        drive(1'b1, 32'h3C051234, 32'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.stall%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
            step();
            chk_out($sformatf("bp.stall%0d", c), C_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk_out("bp.b", C_LU, 32'd0, 32'h1234, 5'd5, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();
        chk("bp.drain.out_valid", {31'b0, out_valid}, 32'd0);

        // Flush with an op held; op presented alongside flush is dropped.
        out_ready = 1'b0;
        drive(1'b1, 32'h01093822, 32'd10, 32'd3);
        step();
        chk_out("fl.held", C_SUB, 32'd10, 32'd3, 5'd7, 1'b1, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h34068000, 32'd0, 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("fl.out_valid", {31'b0, out_valid}, 32'd0);
        step();
        chk("fl.dropped", {31'b0, out_valid}, 32'd0);
        chk("fl.payload_kept", opa, 32'd10);

        // Illegal opcode.
        drive(1'b1, 32'hFC000000, 32'h55, 32'h66);
        step();
        chk_out("ill", C_AND, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 32'h00221820, 32'd5, 32'd7);
`ifdef ALU_DECODE_TRAP_EN
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("trap%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
            step();
            chk($sformatf("trap%0d.out_valid", c), {31'b0, out_valid}, 32'd0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("trap.flush.out_valid", {31'b0, out_valid}, 32'd0);
        chk("trap.cleared.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk_out("trap.add", C_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
`else
        chk("ill.next.in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk_out("ill.add", C_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
`endif
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
